keypad_scan: RTL and testbench
==============================

KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 48000, meaning clk cycles spent on each driven row (minimum 4).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 960000, meaning consecutive clk cycles a column pattern must stay stable to be accepted (minimum 2).
REQ-003 SHALL have port clk  input  1  system clock, all state on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cols  input  4  keypad column sense, active-high, asynchronous to clk.
REQ-006 SHALL have port rows  output  4  keypad row drive, one-hot, active-high.
REQ-007 SHALL have port col_row_comb  output  9  decoded key: bit 8 = key held, bits 7:4 = column one-hot, bits 3:0 = row one-hot; consumed by colrowseg.
REQ-008 SHALL have port key_new  output  1  one-cycle strobe when a new press is accepted.

Function
REQ-009 SHALL pass cols through a two-flop synchronizer; the FSM uses only the synchronized value scols.
REQ-010 SHALL implement states SCAN, DB_PRESS, HELD and DB_RELEASE.
REQ-011 SCAN: a divider counts 0..SCAN_DIV-1; at terminal count, if scols == 0, rows rotates left (0001->0010->0100->1000->0001) and the divider restarts.
REQ-012 SCAN: at terminal count with scols != 0, the block SHALL latch cand = scols, freeze rows, clear the debounce counter and enter DB_PRESS.
REQ-013 DB_PRESS: each cycle with scols == cand increments the debounce counter; any cycle with scols != cand returns to SCAN, rows unchanged, divider restarted.
REQ-014 DB_PRESS: when the counter reaches DEBOUNCE_CYCLES-1 and cand is one-hot, the block SHALL enter HELD, load col_row_comb = {1, cand, rows} and pulse key_new for exactly that cycle.
REQ-015 DB_PRESS: when the counter reaches DEBOUNCE_CYCLES-1 and cand is not one-hot (multiple columns), the block SHALL return to SCAN with no output change and no key_new.
REQ-016 HELD: rows stays frozen; when scols == 0, the block SHALL clear the debounce counter and enter DB_RELEASE.
REQ-017 DB_RELEASE: any nonzero scols returns to HELD; DEBOUNCE_CYCLES consecutive zero cycles enter SCAN and clear col_row_comb[8] only.
REQ-018 col_row_comb[7:0] SHALL retain the last accepted key after release until the next accepted press.
REQ-019 A second key pressed while in HELD or DB_RELEASE SHALL be ignored; only a full release followed by a new press can produce key_new.
REQ-020 Counters SHALL be sized with $clog2 of their parameter; wrap-around beyond terminal count is not permitted.
REQ-021 All outputs SHALL be registered; rows is never zero and never multi-hot.

Reset
REQ-022 Asserting reset (low) SHALL immediately force the state to SCAN, rows = 4'b0001, col_row_comb = 9'b0, key_new = 0, clear all counters and the synchronizer, and abort any debounce in progress.
REQ-023 After reset deasserts, the first row advance SHALL occur SCAN_DIV cycles later.

Verification (SCAN_DIV=4, DEBOUNCE_CYCLES=8)
REQ-024 Idle, cols = 0 after reset -> rows cycles 0001,0010,0100,1000,0001 every 4 clk; col_row_comb stays 0; key_new never asserts.
REQ-025 cols = 4'b0010 held high only while rows = 4'b0100, for 40 cycles -> col_row_comb = 9'b1_0010_0100, key_new high for exactly one cycle, rows frozen at 0100.
REQ-026 Bounce: cols toggles 0010/0000 every 3 cycles in row 0001, then settles at 0010 -> exactly one key_new; col_row_comb = 9'b1_0010_0001.
REQ-027 Release after REQ-025 scenario: cols = 0 for 8 cycles -> col_row_comb = 9'b0_0010_0100, scanning resumes; a 5-cycle release glitch keeps bit 8 = 1.
REQ-028 Two columns, cols = 4'b0011 stable -> no key_new, col_row_comb unchanged; reset pulsed low mid-DB_PRESS -> rows = 0001 and col_row_comb = 0 immediately.

Source files
------------

// File: rtl/keypad_scan.sv
// -----------------------------------------------------------------------------
// keypad_scan
//
// Scans a 4x4 active-high key matrix and reports one debounced key press at a
// time. One row is driven at a time; the column lines are synchronised and
// watched. When a column pattern shows up at the end of a row's dwell time the
// scanner freezes on that row and debounces the pattern. A stable single-column
// pattern is accepted as a key. The key then has to be released (debounced as
// well) before another key can be reported.
//
// Parameters
//   SCAN_DIV        clk cycles spent driving each row (>= 4, so the two-flop
//                   column synchroniser settles before the row is judged)
//   DEBOUNCE_CYCLES consecutive clk cycles a pattern must hold to be accepted,
//                   and consecutive all-zero cycles needed for release (>= 2)
//
// Ports
//   clk          system clock, all state on its rising edge
//   reset        asynchronous, active-low reset
//   cols[3:0]    column sense from the keypad, active-high, asynchronous
//   rows[3:0]    row drive, always exactly one bit set
//   col_row_comb {key held, column one-hot, row one-hot}; bits 7:0 keep the
//                last accepted key after release
//   key_new      one-cycle strobe on the cycle a new press is accepted
//   state_dbg    current FSM state (SCAN=0, DB_PRESS=1, HELD=2, DB_RELEASE=3)
// -----------------------------------------------------------------------------
module keypad_scan #(
    parameter int SCAN_DIV        = 48000,
    parameter int DEBOUNCE_CYCLES = 960000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cols,
    output logic [3:0] rows,
    output logic [8:0] col_row_comb,
    output logic       key_new,
    output logic [1:0] state_dbg
);

    // -------------------------------------------------------------------------
    // Counter sizing
    // -------------------------------------------------------------------------
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    // The debounce counter is cleared on the cycle that first sees the new
    // pattern (latch in SCAN, first zero in HELD). That cycle is the first of
    // the DEBOUNCE_CYCLES-long run, so the decision is taken on the cycle in
    // which the counter would step from DEBOUNCE_CYCLES-2 to DEBOUNCE_CYCLES-1.
    // The counter therefore never runs past its terminal value.
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 2);
    localparam logic [DB_W-1:0]  DB_ONE   = DB_W'(1);

    // -------------------------------------------------------------------------
    // FSM states
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        SCAN       = 2'd0,
        DB_PRESS   = 2'd1,
        HELD       = 2'd2,
        DB_RELEASE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        rows_q, rows_d;
    logic [3:0]        cand_q, cand_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DB_W-1:0]   db_q, db_d;
    logic [8:0]        crc_q, crc_d;
    logic              key_new_q, key_new_d;

    // -------------------------------------------------------------------------
    // Column synchroniser
    // -------------------------------------------------------------------------
    logic [3:0] cols_meta;
    logic [3:0] scols;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cols_meta <= 4'b0000;
            scols     <= 4'b0000;
        end else begin
            cols_meta <= cols;
            scols     <= cols_meta;
        end
    end

    // A pattern with more than one column set cannot be decoded to one key.
    logic cand_one_hot;
    assign cand_one_hot = (cand_q != 4'b0000) && ((cand_q & (cand_q - 4'd1)) == 4'b0000);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= SCAN;
            rows_q    <= 4'b0001;
            cand_q    <= 4'b0000;
            div_q     <= '0;
            db_q      <= '0;
            crc_q     <= 9'b0;
            key_new_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rows_q    <= rows_d;
            cand_q    <= cand_d;
            div_q     <= div_d;
            db_q      <= db_d;
            crc_q     <= crc_d;
            key_new_q <= key_new_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        rows_d    = rows_q;
        cand_d    = cand_q;
        div_d     = div_q;
        db_d      = db_q;
        crc_d     = crc_q;
        key_new_d = 1'b0;

        case (state_q)
            SCAN: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (scols == 4'b0000) begin
                        rows_d = {rows_q[2:0], rows_q[3]};
                    end else begin
                        // Row stays frozen so the pattern keeps reading the
                        // same row while it is debounced.
                        cand_d  = scols;
                        db_d    = '0;
                        state_d = DB_PRESS;
                    end
                end else begin
                    div_d = div_q + DIV_ONE;
                end
            end

            DB_PRESS: begin
                if (scols != cand_q) begin
                    state_d = SCAN;
                    div_d   = '0;
                end else if (db_q == DB_LAST) begin
                    if (cand_one_hot) begin
                        state_d   = HELD;
                        crc_d     = {1'b1, cand_q, rows_q};
                        key_new_d = 1'b1;
                    end else begin
                        // Several columns at once: ambiguous, drop it and
                        // resume scanning from the same row.
                        state_d = SCAN;
                        div_d   = '0;
                    end
                end else begin
                    db_d = db_q + DB_ONE;
                end
            end

            HELD: begin
                // Extra keys only add column bits; they are ignored until
                // every column has gone quiet.
                if (scols == 4'b0000) begin
                    db_d    = '0;
                    state_d = DB_RELEASE;
                end
            end

            DB_RELEASE: begin
                if (scols != 4'b0000) begin
                    state_d = HELD;
                end else if (db_q == DB_LAST) begin
                    state_d  = SCAN;
                    div_d    = '0;
                    crc_d[8] = 1'b0;
                end else begin
                    db_d = db_q + DB_ONE;
                end
            end

            default: begin
                state_d = SCAN;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs (all straight from flops)
    // -------------------------------------------------------------------------
    assign rows         = rows_q;
    assign col_row_comb = crc_q;
    assign key_new      = key_new_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_keypad_scan.sv
// -----------------------------------------------------------------------------
// tb_keypad_scan
//
// Drives keypad_scan (SCAN_DIV=4, DEBOUNCE_CYCLES=8) through a keypad matrix
// model: a pressed key at (r,c) pulls column c high while row r is driven.
// Random presses with bounce, release glitches and stray second keys are
// judged against rules for what a debounced keypad must report.
// -----------------------------------------------------------------------------
module tb_keypad_scan;

    localparam int SCAN_DIV = 4;
    localparam int DB       = 8;
    localparam logic [1:0] ST_DB_PRESS = 2'd1;

    // -------------------------------------------------------------------------
    // Clock / reset / DUT
    // -------------------------------------------------------------------------
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] cols;
    logic [3:0] rows;
    logic [8:0] col_row_comb;
    logic       key_new;
    logic [1:0] state_dbg;

    always #5 clk = ~clk;

    keypad_scan #(
        .SCAN_DIV        (SCAN_DIV),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cols         (cols),
        .rows         (rows),
        .col_row_comb (col_row_comb),
        .key_new      (key_new),
        .state_dbg    (state_dbg)
    );

    // Keypad matrix: keys[r*4+c] is the switch at row r, column c.
    logic [15:0] keys;

    always_comb begin
        cols = 4'b0000;
        for (int r = 0; r < 4; r++) begin
            if (rows[r] === 1'b1) cols = cols | keys[r*4 +: 4];
        end
    end

    // -------------------------------------------------------------------------
    // Checking
    // -------------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] onehot4(input int i);
        return 4'b0001 << i;
    endfunction

    // -------------------------------------------------------------------------
    // Scoreboard: every key_new must match the next expected key
    // -------------------------------------------------------------------------
    logic [8:0] exp_q[$];
    int         kn_total = 0;

    always begin
        @(posedge clk);
        #1;
        check_eq("rows_onehot", {31'b0, $onehot(rows)}, 32'd1);
        if (key_new === 1'b1) begin
            kn_total++;
            check_eq("key_new_expected", {31'b0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                check_eq("key_new_code", {23'b0, col_row_comb}, {23'b0, exp_q.pop_front()});
            end
        end
    end

    // -------------------------------------------------------------------------
    // Driver tasks
    // -------------------------------------------------------------------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_accept(input int kn0, input string tag);
        int n = 0;
        while (kn_total == kn0 && n < 200) begin
            cycles(1);
            n++;
        end
        check_eq(tag, {31'b0, kn_total != kn0}, 32'd1);
    endtask

    logic [7:0] last_key = 8'h00;

    // One complete key transaction: optional bounce, press, release glitch,
    // stray second key, full release.
    task automatic key_cycle(input int it);
        int         r, c, r2, c2, kn0, glen, n;
        logic [8:0] exp_key;
        logic [3:0] rows_before;
        logic       changed;

        r       = $urandom_range(0, 3);
        c       = $urandom_range(0, 3);
        exp_key = {1'b1, onehot4(c), onehot4(r)};
        kn0     = kn_total;
        exp_q.push_back(exp_key);

        // Bounce: on-phases shorter than the debounce window must not count.
        if ($urandom_range(0, 1) == 1) begin
            int nb = $urandom_range(2, 5);
            for (int b = 0; b < nb; b++) begin
                keys[r*4 + c] = 1'b1;
                cycles($urandom_range(3, DB - 1));
                keys[r*4 + c] = 1'b0;
                cycles(3);
            end
            check_eq("bounce_no_accept", kn_total - kn0, 32'd0);
        end

        keys[r*4 + c] = 1'b1;
        wait_accept(kn0, "press_accepted");
        cycles(5);
        check_eq("press_one_strobe", kn_total - kn0, 32'd1);
        check_eq("press_code", {23'b0, col_row_comb}, {23'b0, exp_key});
        check_eq("press_rows_frozen", {28'b0, rows}, {28'b0, onehot4(r)});

        // Release glitch: DB or more quiet cycles is a genuine release, so
        // the returning key is a fresh press.
        case (it % 3)
            0:       glen = DB - 1;
            1:       glen = DB;
            default: glen = $urandom_range(1, DB - 2);
        endcase
        if (glen >= DB) exp_q.push_back(exp_key);
        keys[r*4 + c] = 1'b0;
        cycles(glen);
        keys[r*4 + c] = 1'b1;
        cycles(30);
        check_eq("glitch_strobes", kn_total - kn0, (glen >= DB) ? 32'd2 : 32'd1);
        check_eq("glitch_code", {23'b0, col_row_comb}, {23'b0, exp_key});
        check_eq("glitch_rows", {28'b0, rows}, {28'b0, onehot4(r)});

        // A second key while held never produces a strobe.
        kn0 = kn_total;
        if ($urandom_range(0, 1) == 1) begin
            do begin
                r2 = $urandom_range(0, 3);
                c2 = $urandom_range(0, 3);
            end while (r2 == r && c2 == c);
            keys[r2*4 + c2] = 1'b1;
            cycles(20);
            check_eq("second_key_ignored", kn_total - kn0, 32'd0);
            check_eq("second_key_code", {23'b0, col_row_comb}, {23'b0, exp_key});
        end

        // Full release: held bit drops, key code is kept, scanning resumes.
        keys = 16'h0000;
        cycles(20);
        check_eq("release_code", {23'b0, col_row_comb}, {23'b0, 1'b0, exp_key[7:0]});
        check_eq("release_no_strobe", kn_total - kn0, 32'd0);
        rows_before = rows;
        changed     = 1'b0;
        n           = 0;
        while (!changed && n < 3 * SCAN_DIV) begin
            cycles(1);
            changed = (rows != rows_before);
            n++;
        end
        check_eq("scan_resumes", {31'b0, changed}, 32'd1);
        last_key = exp_key[7:0];
    endtask

    // -------------------------------------------------------------------------
    // Main sequence
    // -------------------------------------------------------------------------
    initial begin
        int kn0, c1, c2, r, n;
        logic found;

        keys  = 16'h0000;
        reset = 1'b0;
        cycles(3);
        check_eq("reset_rows", {28'b0, rows}, 32'h1);
        check_eq("reset_code", {23'b0, col_row_comb}, 32'h0);
        check_eq("reset_key_new", {31'b0, key_new}, 32'h0);

        // Idle scan: after edge k past reset release, row (k / SCAN_DIV) % 4.
        reset = 1'b1;
        for (int k = 1; k <= 5 * SCAN_DIV; k++) begin
            @(negedge clk);
            check_eq("idle_rows", {28'b0, rows}, {28'b0, onehot4((k / SCAN_DIV) % 4)});
        end
        check_eq("idle_code", {23'b0, col_row_comb}, 32'h0);
        check_eq("idle_no_strobe", kn_total, 32'd0);

        for (int it = 0; it < 10; it++) key_cycle(it);

        // Two columns on one row: never a key, code untouched.
        r  = $urandom_range(0, 3);
        c1 = $urandom_range(0, 3);
        c2 = (c1 + $urandom_range(1, 3)) % 4;
        kn0 = kn_total;
        keys[r*4 + c1] = 1'b1;
        keys[r*4 + c2] = 1'b1;
        cycles(100);
        check_eq("multi_no_strobe", kn_total - kn0, 32'd0);
        check_eq("multi_code", {23'b0, col_row_comb}, {23'b0, 1'b0, last_key});

        // Reset in the middle of a debounce takes effect without a clock edge.
        found = 1'b0;
        n     = 0;
        while (!found && n < 60) begin
            cycles(1);
            found = (state_dbg == ST_DB_PRESS);
            n++;
        end
        check_eq("multi_debounce_seen", {31'b0, found}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_eq("async_reset_rows", {28'b0, rows}, 32'h1);
        check_eq("async_reset_code", {23'b0, col_row_comb}, 32'h0);
        check_eq("async_reset_key_new", {31'b0, key_new}, 32'h0);
        cycles(2);
        keys = 16'h0000;
        @(negedge clk);
        reset = 1'b1;

        key_cycle(99);

        cycles(5);
        check_eq("scoreboard_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog: the run is far shorter than this.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
